operand_forward_ctrl: RTL
=========================

# operand_forward_ctrl

Pipeline control block that consumes ID-stage source-register addresses, tracks the destination registers of instructions in flight through EX, MEM and WB, and drives the hazard response. It produces registered forwarding-mux selects for the ALU operands, a combinational load-use stall with bubble injection, and a freeze while data memory is busy. It sits beside the ID/EX pipeline register and feeds the ALU-stage operand muxes and the PC / IF-ID / ID-EX enables.

## Interface
- `XLEN_REG`, default 5: register address width.
- `CNT_W`, default 16: stall counter width. Used only with `HAZARD_PERF_CNT_EN`.

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  the ID stage holds a real instruction.
- `id_rs1`, `id_rs2`  in  5 each  ID-stage source register addresses.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the source is actually read.
- `id_rd`  in  5  ID-stage destination register.
- `id_reg_write`  in  1  the ID-stage instruction writes `id_rd`.
- `id_mem_read`  in  1  the ID-stage instruction is a load.
- `mem_busy`  in  1  data memory is not ready and the whole pipeline must hold.
- `fwd_sel_a`, `fwd_sel_b`  out  2 each  registered operand selects for the EX-stage instruction: 00 register file, 01 EX/MEM result, 10 MEM/WB result, 11 never driven.
- `stall_if`  out  1  hold PC and IF/ID (combinational).
- `bubble_ex`  out  1  load NOP into ID/EX (combinational).
- `freeze`  out  1  hold every pipeline register (combinational, equals `mem_busy`).
- `stall_count`  out  CNT_W  number of load-use bubbles issued.

## Operation
- Internal tracking slots: EX, MEM and WB. Each slot holds {rd, reg_write, mem_read}. All fields reset to 0.
- **Advance** (`freeze`=0):
  - WB←MEM and MEM←EX.
  - EX←{id_rd, id_reg_write & id_valid, id_mem_read & id_valid}, or all-zero when `bubble_ex`=1.
- **Freeze** (`freeze`=1): all slots and `fwd_sel_*` hold their values.
- **Match rule.** A source matches a slot when all of these hold: the source is used, `id_valid`=1, slot.reg_write=1, slot.rd≠0, and slot.rd equals the source address.
- **Forward select**, computed on advance and registered for the instruction entering EX:
  - Match against the current EX slot → 01.
  - Otherwise a match against the current MEM slot → 10.
  - Otherwise 00.
  - The newest producer wins.
  - When `bubble_ex`=1, both selects load 00.
- **Load-use hazard** = a match against the EX slot with EX.mem_read=1.
  - `stall_if` = hazard | mem_busy.
  - `bubble_ex` = hazard & ~mem_busy.
- **FSM** (reset state RUN):
  - RUN: pipeline advancing.
  - RUN→FROZEN when `mem_busy`=1.
  - FROZEN→RUN on the first cycle `mem_busy`=0.
  - Hazard evaluation continues in FROZEN, but `bubble_ex` stays masked until the return to RUN. A load-use pending during a freeze therefore bubbles exactly once, on the first RUN cycle.
- Reset mid-operation clears all slots, selects, counter and FSM immediately; no stall is asserted while `reset`=0.

## Timing
- Reset values:
  - `fwd_sel_a`=`fwd_sel_b`=00.
  - `stall_count`=0.
  - `stall_if`=`bubble_ex`=0 (slots empty).
  - `freeze` follows `mem_busy`.
- Stall path: zero-cycle latency from ID inputs and slot state to `stall_if`/`bubble_ex`.
- Select path: selects become valid the edge after the instruction leaves ID and stay stable while it sits in EX.
- Load-use costs exactly one bubble. On the next cycle the load is in MEM, the dependent instruction advances, and its select is 10.
- rs1 and rs2 are evaluated independently; both may forward from different stages in the same cycle.
- rd=0 never forwards and never stalls.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_count` increments by 1 on every edge where `bubble_ex`=1.
  - It saturates at all-ones and never wraps.
- Undefined: the counter logic is omitted and `stall_count` is tied to 0.

## Test plan
- **Back-to-back dependence.** Issue `add x5` then `sub` reading rs1=x5 → one cycle later `fwd_sel_a`=01, `fwd_sel_b`=00, no stall.
- **Distance-2 and priority.** `add x5`, unrelated op, `or` reading x5 → `fwd_sel_a`=10. With x5 written by both EX and MEM slots → 01.
- **Load-use.** `lw x7` then `add` reading rs2=x7 → `stall_if`=`bubble_ex`=1 for exactly one cycle, then `fwd_sel_b`=10. With the macro defined, `stall_count` goes 0→1.
- **x0 filter.** A producer with rd=0 followed by a consumer of x0 → selects 00, no stall.
- **Freeze overlap.** Assert `mem_busy` for 3 cycles during a load-use → `freeze`=1 for 3 cycles, slots and selects unchanged, `bubble_ex`=0 throughout; one bubble on the first RUN cycle.
- **Async reset.** Drop `reset` mid-stall → selects become 00, the counter becomes 0, and `stall_if` drops without waiting for a clock edge.

Source files
------------

// File: rtl/operand_forward_ctrl_if.sv
// operand_forward_ctrl_if: ID-stage operand info in, forwarding selects and stall controls out.
interface operand_forward_ctrl_if #(parameter int XLEN_REG = 5, parameter int CNT_W = 16);
    logic                id_valid;
    logic [XLEN_REG-1:0] id_rs1;
    logic [XLEN_REG-1:0] id_rs2;
    logic                id_rs1_used;
    logic                id_rs2_used;
    logic [XLEN_REG-1:0] id_rd;
    logic                id_reg_write;
    logic                id_mem_read;
    logic                mem_busy;
    logic [1:0]          fwd_sel_a;
    logic [1:0]          fwd_sel_b;
    logic                stall_if;
    logic                bubble_ex;
    logic                freeze;
    logic [CNT_W-1:0]    stall_count;
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write, id_mem_read, mem_busy,
        input  fwd_sel_a, fwd_sel_b, stall_if, bubble_ex, freeze, stall_count
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write, id_mem_read, mem_busy,
        output fwd_sel_a, fwd_sel_b, stall_if, bubble_ex, freeze, stall_count
    );
endinterface

// File: rtl/operand_forward_ctrl.sv
// operand_forward_ctrl: EX/MEM forwarding selects, load-use stall/bubble and memory freeze.
// Optional stall counter enabled by HAZARD_PERF_CNT_EN.
module operand_forward_ctrl #(
    parameter int XLEN_REG = 5,
    parameter int CNT_W    = 16
) (
    input logic                  clk,
    input logic                  reset,
    operand_forward_ctrl_if.slave bus
);
    typedef struct packed {
        logic [XLEN_REG-1:0] rd;
        logic                rw;
        logic                mr;
    } slot_t;
    typedef enum logic {RUN, FROZEN} state_t;
    state_t state, state_nx;
    slot_t  ex, mem;
    logic   adv, hazard, a_ex, a_mem, b_ex, b_mem;
    // Producers already in WB write the register file before ID reads it, so only EX and MEM are matched.
    assign a_ex   = bus.id_rs1_used & bus.id_valid & ex.rw & (ex.rd != '0) & (ex.rd == bus.id_rs1);
    assign a_mem  = bus.id_rs1_used & bus.id_valid & mem.rw & (mem.rd != '0) & (mem.rd == bus.id_rs1);
    assign b_ex   = bus.id_rs2_used & bus.id_valid & ex.rw & (ex.rd != '0) & (ex.rd == bus.id_rs2);
    assign b_mem  = bus.id_rs2_used & bus.id_valid & mem.rw & (mem.rd != '0) & (mem.rd == bus.id_rs2);
    assign hazard = (a_ex | b_ex) & ex.mr;
    always_comb begin
        state_nx = state;
        adv      = 1'b0;
        case (state)
            RUN: begin
                adv      = ~bus.mem_busy;
                state_nx = bus.mem_busy ? FROZEN : RUN;
            end
            FROZEN: begin
                adv      = ~bus.mem_busy;
                state_nx = bus.mem_busy ? FROZEN : RUN;
            end
            default: state_nx = RUN;
        endcase
    end
    assign bus.bubble_ex = hazard & adv;
    assign bus.stall_if  = reset & (hazard | bus.mem_busy);
    assign bus.freeze    = bus.mem_busy;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            ex            <= '0;
            mem           <= '0;
            bus.fwd_sel_a <= 2'b00;
            bus.fwd_sel_b <= 2'b00;
        end else begin
            state <= state_nx;
            if (adv) begin
                mem           <= ex;
                ex            <= bus.bubble_ex ? '0 : {bus.id_rd, bus.id_reg_write & bus.id_valid, bus.id_mem_read & bus.id_valid};
                bus.fwd_sel_a <= bus.bubble_ex ? 2'b00 : a_ex ? 2'b01 : a_mem ? 2'b10 : 2'b00;
                bus.fwd_sel_b <= bus.bubble_ex ? 2'b00 : b_ex ? 2'b01 : b_mem ? 2'b10 : 2'b00;
            end
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (bus.bubble_ex && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
    assign bus.stall_count = cnt;
`else
    assign bus.stall_count = '0;
`endif
endmodule
